// File: rtl/grid_controller.sv
// grid_controller: single-cell falling piece on a 16x16 byte grid.
// Ports: clk, reset (sync, active-high), controller_in[3:0] button code,
//   tetris_grid_in[7:0] registered read data, grid_address[7:0],
//   grid_data_out[7:0], write_en (one grid write per asserted cycle).
module grid_controller #(
  parameter int unsigned TICK_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] controller_in,
  input  logic [7:0] tetris_grid_in,
  output logic [7:0] grid_address,
  output logic [7:0] grid_data_out,
  output logic       write_en
);

  localparam int unsigned TW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [3:0] BTN_LEFT  = 4'b0111;
  localparam logic [3:0] BTN_RIGHT = 4'b1000;
  localparam logic [3:0] BTN_DOWN  = 4'b0101;
  localparam logic [3:0] BTN_START = 4'b0100;

  localparam logic [3:0] SPAWN_ROW  = 4'd0;
  localparam logic [3:0] SPAWN_COL  = 4'd8;
  localparam logic [7:0] SPAWN_ADDR = {SPAWN_ROW, SPAWN_COL};
  localparam logic [7:0] PIECE      = 8'h01;

  typedef enum logic [3:0] {
    SPAWN_RD,
    SPAWN_CHK,
    IDLE,
    MOVE_RD,
    MOVE_CHK,
    ERASE,
    DRAW,
    GAME_OVER,
    CLEAR
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    tgt_row_q, tgt_row_d;
  logic [3:0]    tgt_col_q, tgt_col_d;
  logic          mv_down_q, mv_down_d;
  logic          pend_down_q, pend_down_d;
  logic          pend_left_q, pend_left_d;
  logic          pend_right_q, pend_right_d;
  logic [3:0]    btn_prev_q, btn_prev_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;

  logic       edge_left;
  logic       edge_right;
  logic       edge_down;
  logic       edge_start;
  logic       tick_wrap;
  logic       running;
  logic [3:0] down_row;
  logic [3:0] left_col;
  logic [3:0] right_col;

  // A request fires only on the cycle the code first appears.
  assign edge_left  = (controller_in == BTN_LEFT)
                    && (btn_prev_q != BTN_LEFT);
  assign edge_right = (controller_in == BTN_RIGHT)
                    && (btn_prev_q != BTN_RIGHT);
  assign edge_down  = (controller_in == BTN_DOWN)
                    && (btn_prev_q != BTN_DOWN);
  assign edge_start = (controller_in == BTN_START)
                    && (btn_prev_q != BTN_START);

  assign tick_wrap = (tick_q == TICK_LAST);
  assign running   = (state_q != GAME_OVER)
                  && (state_q != CLEAR);

  assign down_row  = row_q + 4'd1;
  assign left_col  = col_q - 4'd1;
  assign right_col = col_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    tgt_row_d    = tgt_row_q;
    tgt_col_d    = tgt_col_q;
    mv_down_d    = mv_down_q;
    btn_prev_d   = controller_in;
    addr_d       = addr_q;
    wdata_d      = 8'h00;
    we_d         = 1'b0;
    tick_d       = '0;
    pend_down_d  = pend_down_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;

    if (running) begin
      tick_d       = tick_wrap ? '0 : tick_q + TW'(1);
      pend_down_d  = pend_down_q | tick_wrap | edge_down;
      pend_left_d  = pend_left_q | edge_left;
      pend_right_d = pend_right_q | edge_right;
    end

    unique case (state_q)
      SPAWN_RD: begin
        row_d  = SPAWN_ROW;
        col_d  = SPAWN_COL;
        addr_d = SPAWN_ADDR;
        // Straight out of reset the port still shows 0, so hold
        // here one more cycle until the spawn cell is on the bus.
        if (addr_q == SPAWN_ADDR) begin
          state_d = SPAWN_CHK;
        end
      end

      SPAWN_CHK: begin
        if (tetris_grid_in != 8'h00) begin
          state_d = GAME_OVER;
        end else begin
          addr_d  = SPAWN_ADDR;
          wdata_d = PIECE;
          we_d    = 1'b1;
          state_d = DRAW;
        end
      end

      IDLE: begin
        if (pend_down_q) begin
          pend_down_d = tick_wrap | edge_down;
          if (row_q == 4'd15) begin
            addr_d  = SPAWN_ADDR;
            state_d = SPAWN_RD;
          end else begin
            tgt_row_d = down_row;
            tgt_col_d = col_q;
            mv_down_d = 1'b1;
            addr_d    = {down_row, col_q};
            state_d   = MOVE_RD;
          end
        end else if (pend_left_q) begin
          pend_left_d = edge_left;
          if (col_q != 4'd0) begin
            tgt_row_d = row_q;
            tgt_col_d = left_col;
            mv_down_d = 1'b0;
            addr_d    = {row_q, left_col};
            state_d   = MOVE_RD;
          end
        end else if (pend_right_q) begin
          pend_right_d = edge_right;
          if (col_q != 4'd15) begin
            tgt_row_d = row_q;
            tgt_col_d = right_col;
            mv_down_d = 1'b0;
            addr_d    = {row_q, right_col};
            state_d   = MOVE_RD;
          end
        end
      end

      MOVE_RD: begin
        state_d = MOVE_CHK;
      end

      MOVE_CHK: begin
        if (tetris_grid_in != 8'h00) begin
          // Blocked fall freezes the piece where it is.
          if (mv_down_q) begin
            addr_d  = SPAWN_ADDR;
            state_d = SPAWN_RD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          addr_d  = {row_q, col_q};
          we_d    = 1'b1;
          state_d = ERASE;
        end
      end

      ERASE: begin
        addr_d  = {tgt_row_q, tgt_col_q};
        wdata_d = PIECE;
        we_d    = 1'b1;
        row_d   = tgt_row_q;
        col_d   = tgt_col_q;
        state_d = DRAW;
      end

      DRAW: begin
        state_d = IDLE;
      end

      GAME_OVER: begin
        pend_down_d  = 1'b0;
        pend_left_d  = 1'b0;
        pend_right_d = 1'b0;
        if (edge_start) begin
          addr_d  = 8'h00;
          we_d    = 1'b1;
          state_d = CLEAR;
        end
      end

      CLEAR: begin
        pend_down_d  = 1'b0;
        pend_left_d  = 1'b0;
        pend_right_d = 1'b0;
        if (addr_q == 8'hFF) begin
          addr_d  = SPAWN_ADDR;
          state_d = SPAWN_RD;
        end else begin
          addr_d = addr_q + 8'd1;
          we_d   = 1'b1;
        end
      end

      default: begin
        state_d = SPAWN_RD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SPAWN_RD;
      row_q        <= SPAWN_ROW;
      col_q        <= SPAWN_COL;
      tgt_row_q    <= SPAWN_ROW;
      tgt_col_q    <= SPAWN_COL;
      mv_down_q    <= 1'b0;
      pend_down_q  <= 1'b0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      btn_prev_q   <= 4'b0000;
      tick_q       <= '0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tgt_row_q    <= tgt_row_d;
      tgt_col_q    <= tgt_col_d;
      mv_down_q    <= mv_down_d;
      pend_down_q  <= pend_down_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      btn_prev_q   <= btn_prev_d;
      tick_q       <= tick_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
    end
  end

  assign grid_address  = addr_q;
  assign grid_data_out = wdata_q;
  assign write_en      = we_q;

endmodule

// File: tb/tb_grid_controller.sv
// tb_grid_controller: directed checks of grid_controller against
// two behavioural grid memories (gravity and no-gravity instances).
module tb_grid_controller;

  localparam logic [3:0] BTN_LEFT  = 4'b0111;
  localparam logic [3:0] BTN_RIGHT = 4'b1000;
  localparam logic [3:0] BTN_START = 4'b0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_b;
  logic [3:0] ctl_a, ctl_b;
  logic [7:0] rd_a, rd_b;
  logic [7:0] addr_a, addr_b;
  logic [7:0] dout_a, dout_b;
  logic       we_a, we_b;

  logic [7:0] mem_a [256] = '{default: 8'h00};
  logic [7:0] mem_b [256] = '{default: 8'h00};
  logic       poke_en;
  logic [7:0] poke_addr, poke_data;
  int         cyc;
  int         n_total = 0;
  int         n_pass = 0;

  grid_controller #(.TICK_CYCLES(25)) dut_a (
    .clk           (clk),
    .reset         (reset_a),
    .controller_in (ctl_a),
    .tetris_grid_in(rd_a),
    .grid_address  (addr_a),
    .grid_data_out (dout_a),
    .write_en      (we_a)
  );

  grid_controller #(.TICK_CYCLES(2000)) dut_b (
    .clk           (clk),
    .reset         (reset_b),
    .controller_in (ctl_b),
    .tetris_grid_in(rd_b),
    .grid_address  (addr_b),
    .grid_data_out (dout_b),
    .write_en      (we_b)
  );

  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= dout_a;
    if (poke_en) mem_a[poke_addr] <= poke_data;
    rd_a <= mem_a[addr_a];
  end

  always @(posedge clk) begin
    if (we_b) mem_b[addr_b] <= dout_b;
    rd_b <= mem_b[addr_b];
  end

  always @(posedge clk) begin
    if (reset_a) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_we(input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (we_a) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  initial begin
    #400000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    int n, bad, wn, cnt, exp_wn;
    logic [7:0] e_addr, e_data, d_addr, d_data;

    reset_a = 1'b1;
    reset_b = 1'b1;
    ctl_a = 4'b0000;
    ctl_b = 4'b0000;
    poke_en = 1'b0;
    poke_addr = 8'h00;
    poke_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", we_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_data", dout_a, 0);

    // No-gravity instance: twelve LEFT presses.
    reset_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("b_spawn", {we_b, dout_b, addr_b}, {1'b1, 8'h01, 8'd8});
    for (int p = 0; p < 12; p++) begin
      wn = 0;
      e_addr = 8'h00; e_data = 8'hFF;
      d_addr = 8'h00; d_data = 8'hFF;
      ctl_b = BTN_LEFT;
      for (int c = 0; c < 37; c++) begin
        @(negedge clk);
        if (c == 34) ctl_b = 4'b0000;
        if (we_b) begin
          if (wn == 0) begin
            e_addr = addr_b; e_data = dout_b;
          end else if (wn == 1) begin
            d_addr = addr_b; d_data = dout_b;
          end
          wn++;
        end
      end
      exp_wn = (p < 8) ? 2 : 0;
      chk($sformatf("left%0d_writes", p), wn, exp_wn);
      if (p < 8) begin
        chk($sformatf("left%0d_erase", p), {e_data, e_addr},
            {8'h00, 8'(8 - p)});
        chk($sformatf("left%0d_draw", p), {d_data, d_addr},
            {8'h01, 8'(7 - p)});
      end
    end
    reset_b = 1'b1;

    // Gravity instance.
    reset_a = 1'b0;
    @(negedge clk);
    chk("first_addr", addr_a, 8);
    wait_we(2, n);
    chk("spawn_seen", n != 0, 1);
    chk("spawn_write", {dout_a, addr_a}, {8'h01, 8'd8});

    wait_we(40, n);
    chk("tick_seen", n != 0, 1);
    chk("tick_erase", {dout_a, addr_a}, {8'h00, 8'd8});
    @(negedge clk);
    chk("tick_draw", {we_a, dout_a, addr_a}, {1'b1, 8'h01, 8'd24});
    @(negedge clk);
    chk("idle_quiet", {we_a, dout_a, addr_a}, {1'b0, 8'h00, 8'd24});

    // LEFT edge lands on the same clock as a tick wrap.
    while (cyc % 25 != 24) @(negedge clk);
    ctl_a = BTN_LEFT;
    wait_we(10, n);
    chk("both_down_seen", n != 0, 1);
    chk("both_down_erase", {dout_a, addr_a}, {8'h00, 8'd24});
    @(negedge clk);
    chk("both_down_draw", {we_a, dout_a, addr_a}, {1'b1, 8'h01, 8'd40});
    wait_we(10, n);
    chk("both_left_seen", n != 0, 1);
    chk("both_left_erase", {dout_a, addr_a}, {8'h00, 8'd40});
    @(negedge clk);
    chk("both_left_draw", {we_a, dout_a, addr_a}, {1'b1, 8'h01, 8'd39});

    ctl_a = 4'b0000;
    poke(8'd56, 8'h01);
    ctl_a = BTN_RIGHT;
    wait_we(10, n);
    chk("right_erase", {dout_a, addr_a}, {8'h00, 8'd39});
    ctl_a = 4'b0000;
    @(negedge clk);
    chk("right_draw", {we_a, dout_a, addr_a}, {1'b1, 8'h01, 8'd40});

    // Obstacle below: tick locks, next write is the respawn.
    wait_we(40, n);
    chk("lock_seen", n != 0, 1);
    chk("lock_respawn", {dout_a, addr_a}, {8'h01, 8'd8});

    ctl_a = BTN_START;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (we_a) cnt++;
    end
    chk("start_ignored", cnt, 0);
    ctl_a = 4'b0000;

    // Lock at row 0 leaves spawn cell occupied.
    poke(8'd24, 8'h01);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (we_a) cnt++;
    end
    chk("game_over_quiet", cnt, 0);

    ctl_a = BTN_START;
    wait_we(4, n);
    chk("clear_seen", n != 0, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (!(we_a && addr_a == 8'(i) && dout_a == 8'h00)) bad++;
    end
    ctl_a = 4'b0000;
    chk("clear_seq_bad", bad, 0);
    wait_we(5, n);
    chk("clear_spawn_lat", n, 3);
    chk("clear_spawn", {dout_a, addr_a}, {8'h01, 8'd8});

    // Tick counter restarts from zero on leaving CLEAR.
    wait_we(40, n);
    chk("post_clear_tick_lat", n, 26);
    chk("post_clear_erase", {dout_a, addr_a}, {8'h00, 8'd8});
    @(negedge clk);
    chk("post_clear_draw", {we_a, dout_a, addr_a}, {1'b1, 8'h01, 8'd24});

    // Reset during a move aborts the draw.
    ctl_a = BTN_RIGHT;
    wait_we(10, n);
    chk("abort_erase", {dout_a, addr_a}, {8'h00, 8'd24});
    reset_a = 1'b1;
    ctl_a = 4'b0000;
    @(negedge clk);
    chk("abort_rst", {we_a, dout_a, addr_a}, {1'b0, 8'h00, 8'h00});
    reset_a = 1'b0;
    wait_we(4, n);
    chk("abort_respawn_lat", n, 3);
    chk("abort_respawn", {dout_a, addr_a}, {8'h01, 8'd8});
    chk("abort_no_draw", mem_a[25], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
